// File: rtl/device_bus_pkg.sv
// Shared FSM state type, requester ids and device-bus address-map helpers
// used by the device-bus arbiter.
package device_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_B = 1;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  // Control registers live in the low 4 KiB; data devices are decoded by the top byte.
  localparam logic [3:0] CTRL_REGION = 4'h0;
  localparam logic [7:0] UART_DEV_ID = 8'h02;

  function automatic logic is_ctrl_addr(input logic [15:0] addr);
    return addr[15:12] == CTRL_REGION;
  endfunction

  function automatic logic [7:0] ctrl_dev_id(input logic [15:0] addr);
    return addr[11:4];
  endfunction

  function automatic logic [7:0] data_dev_id(input logic [15:0] addr);
    return addr[15:8];
  endfunction

  function automatic logic is_uart_ctrl(input logic [15:0] addr);
    return is_ctrl_addr(addr) && (ctrl_dev_id(addr) == UART_DEV_ID);
  endfunction

endpackage

// File: rtl/dev_arb_rr_pick.sv
// Two-way round-robin picker: masked requests plus last winner give a one-hot winner.
// Bit 0 is requester A, bit 1 is requester B.
module dev_arb_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_b_i,
  input  logic [1:0] mask_i,
  output logic [1:0] win_o
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req_i & ~mask_i;
    win_o    = eligible;
    // On a tie the requester that did not win last time goes first.
    if (eligible == 2'b11) begin
      win_o = last_b_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/device_bus_arbiter.sv
// Round-robin arbiter sharing the device-bus port between CPU (A) and DMA (B),
// one transaction in flight. Optional ownership lock: define DEVICE_ARB_LOCK_EN.
module device_bus_arbiter
  import device_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
`ifdef DEVICE_ARB_LOCK_EN
  input  logic                  a_lock,
  input  logic                  b_lock,
`endif
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  dev_write_enable,
  output logic [ADDR_WIDTH-1:0] dev_address,
  output logic [DATA_WIDTH-1:0] dev_data_in,
  input  logic [DATA_WIDTH-1:0] dev_data_out,
  output logic [1:0]            owner
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic                  lock_q, lock_d;
  logic                  last_b_q;
  logic                  own_b_q;
  logic                  cmd_we_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

  logic [1:0] win;
  logic [1:0] mask;
  logic       own_lock;
  logic       capture;
  logic       txn_done;
  logic       accept;

`ifdef DEVICE_ARB_LOCK_EN
  assign own_lock = own_b_q ? b_lock : a_lock;
`else
  assign own_lock = 1'b0;
`endif

  // While the lock is held the non-owner is hidden from the picker.
  assign mask   = (lock_q && own_lock) ? (own_b_q ? 2'b01 : 2'b10) : 2'b00;
  assign accept = (state_q == IDLE) && (win != 2'b00);

  dev_arb_rr_pick u_pick (
    .req_i    ({b_req, a_req}),
    .last_b_i (last_b_q),
    .mask_i   (mask),
    .win_o    (win)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    capture  = 1'b0;
    txn_done = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = win;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_we_q) begin
          state_d  = IDLE;
          txn_done = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d  = IDLE;
          capture  = 1'b1;
          txn_done = 1'b1;
          rvalid_d = own_b_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lock_d = lock_q;
    if (txn_done) begin
      lock_d = own_lock;
    end else if ((state_q == IDLE) && !own_lock) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      lock_q      <= 1'b0;
      last_b_q    <= 1'b1;
      own_b_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      lock_q   <= lock_d;
      if (accept) begin
        own_b_q     <= win[REQ_B];
        last_b_q    <= win[REQ_B];
        cmd_we_q    <= win[REQ_B] ? b_we    : a_we;
        cmd_addr_q  <= win[REQ_B] ? b_addr  : a_addr;
        cmd_wdata_q <= win[REQ_B] ? b_wdata : a_wdata;
      end
      if (capture) begin
        if (own_b_q) b_rdata_q <= dev_data_out;
        else         a_rdata_q <= dev_data_out;
      end
    end
  end

  assign a_gnt            = gnt_q[REQ_A];
  assign b_gnt            = gnt_q[REQ_B];
  assign a_rvalid         = rvalid_q[REQ_A];
  assign b_rvalid         = rvalid_q[REQ_B];
  assign a_rdata          = a_rdata_q;
  assign b_rdata          = b_rdata_q;
  assign dev_write_enable = (state_q == ISSUE) && cmd_we_q;
  assign dev_address      = cmd_addr_q;
  assign dev_data_in      = cmd_wdata_q;
  assign owner            = (state_q == IDLE) ? OWNER_NONE : (own_b_q ? OWNER_B : OWNER_A);

endmodule

// File: tb/tb_device_bus_arbiter.sv
// Directed bench for device_bus_arbiter: vector table of single transactions
// plus hand sequences for contention, reset-in-flight, long read latency and lock.
module tb_device_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
`ifdef DEVICE_ARB_LOCK_EN
  logic        a_lock = 1'b0, b_lock = 1'b0;
`endif

  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, dev_write_enable;
  logic [15:0] a_rdata, b_rdata, dev_address, dev_data_in;
  logic [15:0] dev_data_out = '0;
  logic [1:0]  owner;

  logic        a_gnt3, b_gnt3, a_rvalid3, b_rvalid3, dev_write_enable3;
  logic [15:0] a_rdata3, b_rdata3, dev_address3, dev_data_in3;
  logic [1:0]  owner3;
  logic [15:0] cyc = 16'h1000;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:255];

  always #5 clock = ~clock;

  device_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(1)) u_dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef DEVICE_ARB_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .dev_write_enable(dev_write_enable),
    .dev_address(dev_address), .dev_data_in(dev_data_in), .dev_data_out(dev_data_out),
    .owner(owner)
  );

  device_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
`ifdef DEVICE_ARB_LOCK_EN
    .a_lock(a_lock), .b_lock(b_lock),
`endif
    .a_gnt(a_gnt3), .b_gnt(b_gnt3), .a_rvalid(a_rvalid3), .b_rvalid(b_rvalid3),
    .a_rdata(a_rdata3), .b_rdata(b_rdata3), .dev_write_enable(dev_write_enable3),
    .dev_address(dev_address3), .dev_data_in(dev_data_in3), .dev_data_out(cyc),
    .owner(owner3)
  );

  // Device model with registered read data (one cycle of latency).
  always @(posedge clock) begin
    if (dev_write_enable) mem[dev_address[7:0]] <= dev_data_in;
    dev_data_out <= mem[dev_address[7:0]];
  end

  // The long-latency device returns a running cycle stamp so the sampled cycle is visible.
  always @(posedge clock) cyc <= cyc + 16'd1;

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (a_gnt && b_gnt) begin
        errors++;
        $display("FAIL gnt_exclusive: a_gnt=%0b b_gnt=%0b required not both", a_gnt, b_gnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},    {30'd0, b_gnt, a_gnt}, 32'd0);
    check({tag, "_rvalid"}, {30'd0, b_rvalid, a_rvalid}, 32'd0);
    check({tag, "_dev_we"}, {31'd0, dev_write_enable}, 32'd0);
    check({tag, "_dev_addr"}, {16'd0, dev_address}, 32'd0);
    check({tag, "_dev_din"},  {16'd0, dev_data_in}, 32'd0);
    check({tag, "_a_rdata"},  {16'd0, a_rdata}, 32'd0);
    check({tag, "_b_rdata"},  {16'd0, b_rdata}, 32'd0);
    check({tag, "_owner"},    {30'd0, owner}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        a_req;
    logic        a_we;
    logic [15:0] a_addr;
    logic [15:0] a_wdata;
    logic        b_req;
    logic        b_we;
    logic [15:0] b_addr;
    logic [15:0] b_wdata;
    logic        exp_b;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v, input int idx);
    int          gnt_k = -1, we_k = -1, rv_k = -1, we_cnt = 0, rv_cnt = 0;
    logic [1:0]  gnt_seen = 2'b00, rv_seen = 2'b00, own_seen = 2'b00;
    logic [15:0] addr_seen = '0, wd_seen = '0, rd_seen = '0;
    logic        exp_we;
    logic [15:0] exp_addr, exp_wdata;
    string       t;
    t         = $sformatf("vec%0d", idx);
    exp_we    = v.exp_b ? v.b_we : v.a_we;
    exp_addr  = v.exp_b ? v.b_addr : v.a_addr;
    exp_wdata = v.exp_b ? v.b_wdata : v.a_wdata;
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1;
      if ((a_gnt || b_gnt) && gnt_k < 0) begin
        gnt_k = k; gnt_seen = {b_gnt, a_gnt}; own_seen = owner; addr_seen = dev_address;
        a_req = 1'b0; b_req = 1'b0;
      end
      if (dev_write_enable) begin
        we_cnt++; we_k = k; wd_seen = dev_data_in;
      end
      if (a_rvalid || b_rvalid) begin
        rv_cnt++; rv_k = k; rv_seen = {b_rvalid, a_rvalid}; rd_seen = b_rvalid ? b_rdata : a_rdata;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check({t, "_gnt_cycle"}, gnt_k, 1);
    check({t, "_gnt_who"},   {30'd0, gnt_seen}, v.exp_b ? 32'd2 : 32'd1);
    check({t, "_owner"},     {30'd0, own_seen}, v.exp_b ? 32'd2 : 32'd1);
    check({t, "_dev_addr"},  {16'd0, addr_seen}, {16'd0, exp_addr});
    check({t, "_we_count"},  we_cnt, exp_we ? 1 : 0);
    check({t, "_rv_count"},  rv_cnt, exp_we ? 0 : 1);
    if (exp_we) begin
      check({t, "_we_cycle"}, we_k, 1);
      check({t, "_wdata"},    {16'd0, wd_seen}, {16'd0, exp_wdata});
    end else begin
      check({t, "_rv_cycle"}, rv_k, 3);
      check({t, "_rv_who"},   {30'd0, rv_seen}, v.exp_b ? 32'd2 : 32'd1);
      check({t, "_rdata"},    {16'd0, rd_seen}, {16'd0, v.exp_rdata});
    end
  endtask

  initial begin
    int          gcount, last_k, rv_total, gnt3_k, rv3_k, rv3_cnt;
    logic [15:0] stamp, rd3;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h20] = 16'h0100;

    //          a_req a_we  a_addr    a_wdata   b_req b_we  b_addr    b_wdata   exp_b exp_rdata
    vecs[0] = '{1'b1, 1'b1, 16'h0201, 16'h00AB, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0100};
    vecs[2] = '{1'b1, 1'b1, 16'h0030, 16'h1234, 1'b1, 1'b1, 16'h0040, 16'h5678, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 16'h0201, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h00AB};
    vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h0050, 16'hBEEF, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0201, 16'h0000, 1'b1, 16'h00AB};
    vecs[8] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};

    #2 reset = 1'b1;
    #2 check_reset_values("reset");
    @(posedge clock);
    release_reset();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    check("rdata_hold_a", {16'd0, a_rdata}, 32'h0000BEEF);
    check("rdata_hold_b", {16'd0, b_rdata}, 32'h000000AB);

    // Idle bus: no grants, no strobe, address keeps the last command.
    gcount = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      if (a_gnt || b_gnt || dev_write_enable) gcount++;
    end
    check("idle_activity", gcount, 0);
    check("idle_addr_hold", {16'd0, dev_address}, 32'h0000FFFF);

    // Reset while a read waits for data: it must be dropped without rvalid.
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0020;
    @(posedge clock);
    #1;
    check("rst_wait_gnt", {30'd0, b_gnt, a_gnt}, 32'd2);
    b_req = 1'b0;
    @(posedge clock);
    #1;
    check("rst_wait_owner", {30'd0, owner}, 32'd2);
    #2 reset = 1'b1;
    #1 check_reset_values("rst_wait");
    release_reset();
    rv_total = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_rvalid || b_rvalid || a_rvalid3 || b_rvalid3) rv_total++;
      @(posedge clock);
      #1;
    end
    check("rst_wait_no_rvalid", rv_total, 0);

    // Contention: both held high, grants alternate starting with A every 2 cycles.
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0060; a_wdata = 16'h0A0A;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0070; b_wdata = 16'h0B0B;
    gcount = 0;
    last_k = 0;
    for (int k = 1; k <= 40 && gcount < 8; k++) begin
      @(posedge clock);
      #1;
      if (a_gnt || b_gnt) begin
        check($sformatf("rr_gnt%0d", gcount), {30'd0, b_gnt, a_gnt}, (gcount % 2 == 0) ? 32'd1 : 32'd2);
        if (gcount > 0) check($sformatf("rr_spacing%0d", gcount), k - last_k, 2);
        last_k = k;
        gcount++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("rr_gnt_total", gcount, 8);
    repeat (2) @(posedge clock);
    #1;

    // Long read latency: data sampled three cycles after ISSUE, rvalid at N+5.
    reset = 1'b1;
    release_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0020;
    gnt3_k = -1; rv3_k = -1; rv3_cnt = 0; stamp = '0; rd3 = '0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clock);
      #1;
      if ((a_gnt3 || b_gnt3) && gnt3_k < 0) begin
        gnt3_k = k; stamp = cyc; a_req = 1'b0;
      end
      if (a_rvalid3 || b_rvalid3) begin
        rv3_cnt++; rv3_k = k; rd3 = a_rdata3;
      end
    end
    a_req = 1'b0;
    check("rl3_gnt_cycle", gnt3_k, 1);
    check("rl3_rv_cycle", rv3_k, 5);
    check("rl3_rv_count", rv3_cnt, 1);
    check("rl3_rdata", {16'd0, rd3}, {16'd0, stamp + 16'd3});
    check("rl3_b_rvalid_never", {31'd0, b_rvalid3}, 32'd0);

`ifdef DEVICE_ARB_LOCK_EN
    // Lock: A keeps the bus across three writes and while a_lock stays high in IDLE.
    reset = 1'b1;
    release_reset();
    a_lock = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0021; a_wdata = 16'h0055;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0031; b_wdata = 16'h0066;
    gcount = 0;
    rv_total = 0;
    for (int k = 1; k <= 30 && gcount < 3; k++) begin
      @(posedge clock);
      #1;
      if (b_gnt) rv_total++;
      if (a_gnt) gcount++;
      if (gcount == 3) a_req = 1'b0;
    end
    check("lock_a_gnts", gcount, 3);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      if (b_gnt) rv_total++;
    end
    check("lock_b_masked", rv_total, 0);
    a_lock = 1'b0;
    @(posedge clock);
    #1;
    check("lock_release_gnt", {30'd0, b_gnt, a_gnt}, 32'd2);
    b_req = 1'b0;
    repeat (2) @(posedge clock);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
